// File: rtl/demux_1x2_32_buf.sv
// ----------------------------------------------------------------------------
// demux_1x2_32_buf
// Registered 1-to-2 demultiplexer. A single source stream is steered word by
// word to one of two sink streams. Each sink has its own 2-entry FIFO, so a
// stalled sink never blocks traffic bound for the other one.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_select      source word and destination (0 = a, 1 = b)
//   in_valid/in_ready      source handshake (in_ready depends only on
//                          in_select and registered FIFO occupancy)
//   a_data/a_valid/a_ready sink a handshake, a_data is the FIFO a head
//   b_data/b_valid/b_ready sink b handshake, b_data is the FIFO b head
//   a_count/b_count        wrapping count of words delivered per sink
// ----------------------------------------------------------------------------
module demux_1x2_32_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam int unsigned NUM_OUT = 2;
    localparam int unsigned OCC_W   = 2;

    localparam logic [OCC_W-1:0] OCC_EMPTY = OCC_W'(0);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(2);

    // Per-output FIFO state: head is the presented word, tail the second slot.
    logic [WIDTH-1:0] head_q [NUM_OUT];
    logic [WIDTH-1:0] head_d [NUM_OUT];
    logic [WIDTH-1:0] tail_q [NUM_OUT];
    logic [WIDTH-1:0] tail_d [NUM_OUT];
    logic [OCC_W-1:0] occ_q  [NUM_OUT];
    logic [OCC_W-1:0] occ_d  [NUM_OUT];
    logic [CNT_W-1:0] cnt_q  [NUM_OUT];
    logic [CNT_W-1:0] cnt_d  [NUM_OUT];

    logic sink_rdy [NUM_OUT];
    logic push     [NUM_OUT];
    logic pop      [NUM_OUT];

    assign sink_rdy[0] = a_ready;
    assign sink_rdy[1] = b_ready;

    // Ready looks only at the selected FIFO's registered occupancy.
    assign in_ready = in_select ? (occ_q[1] != OCC_FULL) : (occ_q[0] != OCC_FULL);

    // FIFO next-state and delivery counters.
    always_comb begin
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            occ_d[i]  = occ_q[i];
            cnt_d[i]  = cnt_q[i];
            push[i]   = in_valid & in_ready & (in_select == 1'(i));
            pop[i]    = (occ_q[i] != OCC_EMPTY) & sink_rdy[i];

            case (occ_q[i])
                OCC_EMPTY: begin
                    if (push[i]) begin
                        head_d[i] = in_data;
                        occ_d[i]  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    // Simultaneous push/pop: incoming word replaces the head.
                    if (push[i] && pop[i]) begin
                        head_d[i] = in_data;
                    end else if (push[i]) begin
                        tail_d[i] = in_data;
                        occ_d[i]  = OCC_FULL;
                    end else if (pop[i]) begin
                        occ_d[i]  = OCC_EMPTY;
                    end
                end
                default: begin
                    // Full: push is blocked by in_ready, only pops occur.
                    if (pop[i]) begin
                        head_d[i] = tail_q[i];
                        occ_d[i]  = OCC_ONE;
                    end
                end
            endcase

            if (pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards all in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                occ_q[i]  <= OCC_EMPTY;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                occ_q[i]  <= occ_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign a_data  = head_q[0];
    assign b_data  = head_q[1];
    assign a_valid = (occ_q[0] != OCC_EMPTY);
    assign b_valid = (occ_q[1] != OCC_EMPTY);
    assign a_count = cnt_q[0];
    assign b_count = cnt_q[1];

endmodule

// File: tb/tb_demux_1x2_32_buf.sv
// ----------------------------------------------------------------------------
// tb_demux_1x2_32_buf
// Directed bench for demux_1x2_32_buf with CNT_W = 4 so counter wrap is
// reachable quickly. Inputs change and outputs are sampled 1 ns after the
// rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_1x2_32_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    int checks;
    int failures;

    demux_1x2_32_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_select(in_select),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_data   = '0;
        in_select = 1'b0;
        in_valid  = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        rst_n     = 1'b0;
        #7;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got %b exp 0", a_valid); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got %b exp 0", b_valid); end
        checks++; if (a_data !== 32'h0) begin failures++; $display("FAIL reset_a_data got %h exp 0", a_data); end
        checks++; if (b_data !== 32'h0) begin failures++; $display("FAIL reset_b_data got %h exp 0", b_data); end
        checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL reset_a_count got %0d exp 0", a_count); end
        checks++; if (b_count !== 4'd0) begin failures++; $display("FAIL reset_b_count got %0d exp 0", b_count); end
        in_select = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_a got %b exp 1", in_ready); end
        in_select = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_b got %b exp 1", in_ready); end
    endtask

    task automatic test_single_steer();
        do_reset();
        a_ready   = 1'b1;
        in_data   = 32'hABCDEFF0;
        in_select = 1'b0;
        in_valid  = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL single_a_valid got %b exp 1", a_valid); end
        checks++; if (a_data !== 32'hABCDEFF0) begin failures++; $display("FAIL single_a_data got %h exp abcdeff0", a_data); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL single_b_valid got %b exp 0", b_valid); end
        checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL single_a_count_pre got %0d exp 0", a_count); end
        step();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL single_a_valid_after got %b exp 0", a_valid); end
        checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL single_a_count got %0d exp 1", a_count); end
        checks++; if (b_count !== 4'd0) begin failures++; $display("FAIL single_b_count got %0d exp 0", b_count); end
        checks++; if (a_data !== 32'hABCDEFF0) begin failures++; $display("FAIL single_a_data_hold got %h exp abcdeff0", a_data); end
    endtask

    task automatic test_alternate();
        do_reset();
        a_ready   = 1'b1;
        b_ready   = 1'b1;
        in_data   = 32'h12345678;
        in_select = 1'b1;
        in_valid  = 1'b1;
        step();
        in_data   = 32'hABCDEFF0;
        in_select = 1'b0;
        checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL alt_b_valid got %b exp 1", b_valid); end
        checks++; if (b_data !== 32'h12345678) begin failures++; $display("FAIL alt_b_data got %h exp 12345678", b_data); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL alt_a_valid_early got %b exp 0", a_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL alt_a_valid got %b exp 1", a_valid); end
        checks++; if (a_data !== 32'hABCDEFF0) begin failures++; $display("FAIL alt_a_data got %h exp abcdeff0", a_data); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL alt_b_valid_after got %b exp 0", b_valid); end
        checks++; if (b_count !== 4'd1) begin failures++; $display("FAIL alt_b_count_mid got %0d exp 1", b_count); end
        step();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL alt_a_valid_after got %b exp 0", a_valid); end
        checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL alt_a_count got %0d exp 1", a_count); end
        checks++; if (b_count !== 4'd1) begin failures++; $display("FAIL alt_b_count got %0d exp 1", b_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_ready   = 1'b0;
        in_select = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000001;
        step();
        checks++; if (a_data !== 32'h00000001) begin failures++; $display("FAIL bp_first_head got %h exp 00000001", a_data); end
        in_data = 32'h00000002;
        step();
        in_data = 32'h00000003;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
        checks++; if (a_data !== 32'h00000001) begin failures++; $display("FAIL bp_hold_head got %h exp 00000001", a_data); end
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready2 got %b exp 0", in_ready); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got %b exp 1", a_valid); end
        checks++; if (a_data !== 32'h00000001) begin failures++; $display("FAIL bp_hold_head2 got %h exp 00000001", a_data); end
        a_ready = 1'b1;
        step();
        checks++; if (a_data !== 32'h00000002) begin failures++; $display("FAIL bp_second_head got %h exp 00000002", a_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_reopen got %b exp 1", in_ready); end
        checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL bp_count1 got %0d exp 1", a_count); end
        step();
        in_valid = 1'b0;
        checks++; if (a_data !== 32'h00000003) begin failures++; $display("FAIL bp_third_head got %h exp 00000003", a_data); end
        checks++; if (a_count !== 4'd2) begin failures++; $display("FAIL bp_count2 got %0d exp 2", a_count); end
        step();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got %b exp 0", a_valid); end
        checks++; if (a_count !== 4'd3) begin failures++; $display("FAIL bp_count3 got %0d exp 3", a_count); end
    endtask

    task automatic test_isolation();
        do_reset();
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        in_select = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000011;
        step();
        in_data   = 32'h00000022;
        step();
        in_select = 1'b1;
        in_data   = 32'hDEADBEEF;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL iso_in_ready_b got %b exp 1", in_ready); end
        step();
        in_valid  = 1'b0;
        checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL iso_b_valid got %b exp 1", b_valid); end
        checks++; if (b_data !== 32'hDEADBEEF) begin failures++; $display("FAIL iso_b_data got %h exp deadbeef", b_data); end
        checks++; if (a_data !== 32'h00000011) begin failures++; $display("FAIL iso_a_head got %h exp 00000011", a_data); end
        in_select = 1'b0; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL iso_a_still_full got %b exp 0", in_ready); end
        a_ready = 1'b1;
        step();
        checks++; if (a_data !== 32'h00000022) begin failures++; $display("FAIL iso_a_second got %h exp 00000022", a_data); end
        checks++; if (b_data !== 32'hDEADBEEF) begin failures++; $display("FAIL iso_b_hold got %h exp deadbeef", b_data); end
        checks++; if (b_count !== 4'd0) begin failures++; $display("FAIL iso_b_count got %0d exp 0", b_count); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_word;
        do_reset();
        b_ready   = 1'b1;
        in_select = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_data = 32'h1000 + 32'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
            step();
            exp_word = 32'h1000 + 32'(i);
            checks++; if (b_valid !== 1'b1 || b_data !== exp_word) begin failures++; $display("FAIL stream_b_data[%0d] got %h/%b exp %h/1", i, b_data, b_valid, exp_word); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got %b exp 0", b_valid); end
        checks++; if (b_count !== 4'd2) begin failures++; $display("FAIL stream_wrap_count got %0d exp 2", b_count); end
        checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL stream_a_count got %0d exp 0", a_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_ready   = 1'b1;
        b_ready   = 1'b1;
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 32'hA0000001;
        step();
        in_select = 1'b1;
        in_data   = 32'hB0000001;
        step();
        in_valid  = 1'b0;
        step();
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        in_valid  = 1'b1;
        in_select = 1'b0; in_data = 32'hA0000002; step();
        in_select = 1'b0; in_data = 32'hA0000003; step();
        in_select = 1'b1; in_data = 32'hB0000002; step();
        in_select = 1'b1; in_data = 32'hB0000003; step();
        in_valid  = 1'b0;
        checks++; if (a_count !== 4'd1 || b_count !== 4'd1) begin failures++; $display("FAIL mid_pre_counts got %0d/%0d exp 1/1", a_count, b_count); end
        checks++; if (a_valid !== 1'b1 || b_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got %b/%b exp 1/1", a_valid, b_valid); end
        #1; in_select = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_pre_full_b got %b exp 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got %b/%b exp 0/0", a_valid, b_valid); end
        checks++; if (a_count !== 4'd0 || b_count !== 4'd0) begin failures++; $display("FAIL mid_async_counts got %0d/%0d exp 0/0", a_count, b_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready_b got %b exp 1", in_ready); end
        in_select = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready_a got %b exp 1", in_ready); end
        step();
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid got %b/%b exp 0/0", a_valid, b_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_single_steer();
        test_alternate();
        test_backpressure();
        test_isolation();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x2_32_buf.md
Name: demux_1x2_32_buf

Overview:
- Registered 1-to-2 demultiplexer. It is the distribution counterpart of the 2x1 32-bit mux: one 32-bit source stream is steered by a per-word select to one of two sink streams.
- Each output has a 2-entry FIFO, so a stalled sink does not block traffic bound for the other sink while that sink's FIFO has space.
- Per-output transfer counters support debug and verification.
- Sits between a single producer and two consumers in the datapath.

Parameters:
- WIDTH, 32, data word width.
- CNT_W, 16, width of each delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  source word.
- in_select  input  1  destination: 0 = output a, 1 = output b; sampled with in_data.
- in_valid  input  1  source word present.
- in_ready  output  1  block accepts a word this cycle.
- a_data  output  WIDTH  head word of FIFO a.
- a_valid  output  1  FIFO a non-empty.
- a_ready  input  1  sink a accepts.
- b_data  output  WIDTH  head word of FIFO b.
- b_valid  output  1  FIFO b non-empty.
- b_ready  input  1  sink b accepts.
- a_count  output  CNT_W  words delivered on output a.
- b_count  output  CNT_W  words delivered on output b.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - both FIFOs empty; a_valid = b_valid = 0.
  - a_data = b_data = 0; a_count = b_count = 0.
  - all in-flight words are discarded, including a reset asserted mid-transfer.
- Ready:
  - in_ready = (in_select ? ~full_b : ~full_a); combinational from in_select and registered occupancy only.
  - in_ready must not depend on a_ready or b_ready. There is no pass-through when full.
- Accept: a word is accepted when in_valid & in_ready at the rising clk edge. It is pushed into the FIFO chosen by in_select.
- Deliver:
  - Output x transfers when x_valid & x_ready at the rising edge; the head is popped.
  - x_count increments by 1 and wraps modulo 2^CNT_W. There is no saturation.
- Latency: an accepted word into an empty FIFO appears on x_data with x_valid = 1 in the cycle after the accepting edge. Minimum latency is 1 cycle, with no combinational path from input to output.
- FIFO (each, independent):
  - depth 2; occupancy 0, 1 or 2.
  - Push only: occupancy +1. Pop only: occupancy -1. Push and pop in the same edge: occupancy unchanged.
  - Push into an occupancy-1 FIFO with simultaneous pop: the new word becomes head next cycle, so order is preserved.
  - Push at occupancy 2 is impossible by construction, because in_ready = 0.
  - Pop at occupancy 0 is ignored, because x_valid = 0.
- Output stability:
  - While x_valid = 1 and x_ready = 0, x_data and x_valid hold constant.
  - x_data when x_valid = 0 holds its last value, or 0 after reset.
- Ordering: words to the same output leave in acceptance order. There is no ordering relation between a and b.
- Independence:
  - A full FIFO a does not stall words selected for b, and vice versa.
  - Sustained throughput is 1 word/cycle per output while its sink is ready.
- Counters: update on the same edge as the pop. Both counters may update on the same edge.
- Protocol requirement on the source: while in_valid = 1 and in_ready = 0, the source holds in_data and in_select stable. The block does not check this.

Test Plan:
- Single steer:
  - Stimulus: reset; then in_data = 32'hABCDEFF0, in_select = 0, in_valid for 1 cycle; a_ready = 1.
  - Required response: next cycle a_data = ABCDEFF0, a_valid = 1; following cycle a_valid = 0, a_count = 1; b_valid stays 0 and b_count stays 0.
- Alternate steer:
  - Stimulus: back-to-back words 12345678 (select 1), ABCDEFF0 (select 0); both sinks ready.
  - Required response: b receives 12345678 and a receives ABCDEFF0, each 1 cycle after its accept; counts a = 1, b = 1.
- Backpressure and full:
  - Stimulus: a_ready = 0; push 3 words to a (00000001, 00000002, 00000003).
  - Required response: first two accepted; in_ready = 0 for the third while in_select = 0; a_data holds 00000001.
  - Stimulus, continued: raise a_ready.
  - Required response: 00000001 then 00000002, then the third word is accepted and delivered; a_count = 3.
- Isolation:
  - Stimulus: with FIFO a full and a_ready = 0, present select = 1 word DEADBEEF.
  - Required response: in_ready = 1; b_data = DEADBEEF next cycle; FIFO a contents unchanged.
- Streaming and wrap:
  - Stimulus: CNT_W = 4; stream 18 words to b at 1/cycle with b_ready = 1.
  - Required response: no in_ready drop; order preserved; b_count = 2 after wrap.
- Reset mid-operation:
  - Stimulus: both FIFOs holding 2 words; pulse rst_n low between clock edges.
  - Required response: a_valid, b_valid and both counts go to 0 immediately; in_ready = 1 after release.
